// File: rtl/dbus_sram_bridge.sv
// Polaris D-port responder: runs one sized load/store as 1-4 halfword beats on a
// 16-bit asynchronous SRAM and returns an extended, registered result with dack_o.
module dbus_sram_bridge #(
    parameter int ADDR_W = 19,
    parameter int WAIT   = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              dcyc_i,
    input  logic              dstb_i,
    input  logic              dwe_i,
    input  logic [1:0]        dsiz_i,
    input  logic              dsigned_i,
    input  logic [63:0]       dadr_i,
    input  logic [63:0]       ddat_i,
    output logic [63:0]       ddat_o,
    output logic              dack_o,
    output logic [ADDR_W-1:0] sadr_o,
    output logic [15:0]       sdat_o,
    input  logic [15:0]       sdat_i,
    output logic              soe_o,
    output logic              swe_o,
    output logic [1:0]        sbe_o
);

    typedef enum logic [1:0] {IDLE, BEAT, ACK} state_t;

    localparam logic [3:0] WaitLast = 4'(WAIT);

    state_t            state_q;
    logic              we_q, sgn_q, lane_q;
    logic [1:0]        siz_q, lastBeat_q, beat_q;
    logic [3:0]        wait_q;
    logic [63:0]       wdat_q, asm_q;
    logic [ADDR_W-1:0] base_q, sadr_q;
    logic [15:0]       sdat_q;
    logic              soe_q, swe_q, dack_q;
    logic [1:0]        sbe_q;
    logic [63:0]       ddat_q;

    logic [ADDR_W-1:0] reqBase_d;
    logic [1:0]        reqLast_d, beatNext_d;
    logic [15:0]       rdHalf_d;
    logic [63:0]       asm_d, ext_d;
    logic              unusedAdrBits;

    assign unusedAdrBits = ^dadr_i[63:ADDR_W+1];

    // Byte stores replicate the byte on both lanes; the lane enables pick the real one.
    function automatic logic [15:0] beatData(input logic [63:0] dat, input logic [1:0] siz,
                                             input logic [1:0] beat);
        if (siz == 2'b00) return {dat[7:0], dat[7:0]};
        return dat[{beat, 4'b0000} +: 16];
    endfunction

    always_comb begin
        reqBase_d = dadr_i[ADDR_W:1];
        case (dsiz_i)
            2'b10:   reqBase_d[0]   = 1'b0;
            2'b11:   reqBase_d[1:0] = 2'b00;
            default: ;
        endcase
        case (dsiz_i)
            2'b10:   reqLast_d = 2'd1;
            2'b11:   reqLast_d = 2'd3;
            default: reqLast_d = 2'd0;
        endcase
        beatNext_d = beat_q + 2'd1;
        rdHalf_d   = sdat_i;
        if (siz_q == 2'b00) rdHalf_d = {8'h00, lane_q ? sdat_i[15:8] : sdat_i[7:0]};
        asm_d = asm_q;
        asm_d[{beat_q, 4'b0000} +: 16] = rdHalf_d;
        // asm_d includes the halfword arriving this edge, so the final beat can be acked directly.
        case (siz_q)
            2'b00:   ext_d = {{56{sgn_q & asm_d[7]}},  asm_d[7:0]};
            2'b01:   ext_d = {{48{sgn_q & asm_d[15]}}, asm_d[15:0]};
            2'b10:   ext_d = {{32{sgn_q & asm_d[31]}}, asm_d[31:0]};
            default: ext_d = asm_d;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            sgn_q      <= 1'b0;
            lane_q     <= 1'b0;
            siz_q      <= 2'b00;
            lastBeat_q <= 2'd0;
            beat_q     <= 2'd0;
            wait_q     <= 4'd0;
            wdat_q     <= 64'h0;
            asm_q      <= 64'h0;
            base_q     <= '0;
            sadr_q     <= '0;
            sdat_q     <= 16'h0;
            soe_q      <= 1'b0;
            swe_q      <= 1'b0;
            sbe_q      <= 2'b00;
            dack_q     <= 1'b0;
            ddat_q     <= 64'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    dack_q <= 1'b0;
                    ddat_q <= 64'h0;
                    if (dcyc_i && dstb_i) begin
                        we_q       <= dwe_i;
                        sgn_q      <= dsigned_i;
                        lane_q     <= dadr_i[0];
                        siz_q      <= dsiz_i;
                        lastBeat_q <= reqLast_d;
                        wdat_q     <= ddat_i;
                        base_q     <= reqBase_d;
                        beat_q     <= 2'd0;
                        wait_q     <= 4'd0;
                        asm_q      <= 64'h0;
                        sadr_q     <= reqBase_d;
                        sdat_q     <= dwe_i ? beatData(ddat_i, dsiz_i, 2'd0) : 16'h0;
                        soe_q      <= ~dwe_i;
                        swe_q      <= dwe_i;
                        sbe_q      <= (dsiz_i == 2'b00) ? (dadr_i[0] ? 2'b10 : 2'b01) : 2'b11;
                        state_q    <= BEAT;
                    end
                end
                BEAT: begin
                    if (wait_q == WaitLast) begin
                        wait_q <= 4'd0;
                        if (!we_q) asm_q <= asm_d;
                        if (beat_q == lastBeat_q) begin
                            soe_q   <= 1'b0;
                            swe_q   <= 1'b0;
                            sbe_q   <= 2'b00;
                            sdat_q  <= 16'h0;
                            dack_q  <= 1'b1;
                            ddat_q  <= we_q ? 64'h0 : ext_d;
                            state_q <= ACK;
                        end else begin
                            beat_q <= beatNext_d;
                            sadr_q <= base_q + {{(ADDR_W-2){1'b0}}, beatNext_d};
                            sdat_q <= we_q ? beatData(wdat_q, siz_q, beatNext_d) : 16'h0;
                        end
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                ACK: begin
                    dack_q  <= 1'b0;
                    ddat_q  <= 64'h0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ddat_o = ddat_q;
    assign dack_o = dack_q;
    assign sadr_o = sadr_q;
    assign sdat_o = sdat_q;
    assign soe_o  = soe_q;
    assign swe_o  = swe_q;
    assign sbe_o  = sbe_q;

endmodule

// File: tb/tb_dbus_sram_bridge.sv
// Bench for dbus_sram_bridge: table of load/store vectors against an SRAM model, with a
// per-cycle scoreboard of expected bus activity, plus reset and abort sequences.
module tb_dbus_sram_bridge;

    localparam int AW = 19;
    localparam int W  = 1;

    logic          clk = 1'b0;
    logic          reset_i, dcyc_i, dstb_i, dwe_i, dsigned_i;
    logic [1:0]    dsiz_i;
    logic [63:0]   dadr_i, ddat_i;
    logic [63:0]   ddat_o;
    logic          dack_o, soe_o, swe_o;
    logic [AW-1:0] sadr_o;
    logic [15:0]   sdat_o, sdat_i;
    logic [1:0]    sbe_o;

    logic [15:0] mem [0:(1<<AW)-1];

    typedef struct {
        logic        we;
        logic [1:0]  siz;
        logic        sgn;
        logic [63:0] adr;
        logic [63:0] wdat;
        logic [63:0] expDat;
        string       name;
    } vec_t;

    typedef struct {
        logic          isAck;
        logic [AW-1:0] sadr;
        logic [1:0]    sbe;
        logic          soe;
        logic          swe;
        logic [15:0]   sdat;
        logic          cmpDat;
        logic [63:0]   ddat;
        string         name;
    } exp_t;

    exp_t expQ[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    dbus_sram_bridge #(.ADDR_W(AW), .WAIT(W)) dut (
        .clk_i(clk), .reset_i(reset_i), .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dwe_i(dwe_i),
        .dsiz_i(dsiz_i), .dsigned_i(dsigned_i), .dadr_i(dadr_i), .ddat_i(ddat_i),
        .ddat_o(ddat_o), .dack_o(dack_o), .sadr_o(sadr_o), .sdat_o(sdat_o), .sdat_i(sdat_i),
        .soe_o(soe_o), .swe_o(swe_o), .sbe_o(sbe_o)
    );

    always #5 clk = ~clk;

    assign sdat_i = soe_o ? mem[sadr_o] : 16'h0000;

    always @(posedge clk) begin
        if (swe_o) begin
            if (sbe_o[0]) mem[sadr_o][7:0]  <= sdat_o[7:0];
            if (sbe_o[1]) mem[sadr_o][15:8] <= sdat_o[15:8];
        end
    end

    task automatic scramble();
        dcyc_i    = 1'b0;
        dstb_i    = 1'b0;
        dwe_i     = 1'($urandom);
        dsiz_i    = 2'($urandom);
        dsigned_i = 1'($urandom);
        dadr_i    = {$urandom, $urandom};
        ddat_i    = {$urandom, $urandom};
    endtask

    task automatic applyStimulus(input vec_t v, output int cycles);
        int            n;
        logic [63:0]   aligned;
        logic [AW-1:0] hw;
        logic [1:0]    sbe;
        logic [63:0]   shifted;
        exp_t          e;
        @(negedge clk);
        dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = v.we; dsiz_i = v.siz;
        dsigned_i = v.sgn; dadr_i = v.adr; ddat_i = v.wdat;
        n       = (v.siz == 2'b11) ? 4 : (v.siz == 2'b10) ? 2 : 1;
        aligned = v.adr & ~(64'(1 << v.siz) - 64'd1);
        hw      = aligned[AW:1];
        sbe     = (v.siz == 2'b00) ? (v.adr[0] ? 2'b10 : 2'b01) : 2'b11;
        for (int k = 0; k < n; k++) begin
            shifted = v.wdat >> (16 * k);
            for (int c = 0; c <= W; c++) begin
                e.isAck  = 1'b0;
                e.sadr   = hw + AW'(k);
                e.sbe    = sbe;
                e.soe    = ~v.we;
                e.swe    = v.we;
                e.sdat   = (v.siz == 2'b00) ? {v.wdat[7:0], v.wdat[7:0]} : shifted[15:0];
                e.cmpDat = v.we;
                e.ddat   = 64'h0;
                e.name   = $sformatf("%s_beat%0d", v.name, k);
                expQ.push_back(e);
            end
        end
        e.isAck = 1'b1; e.sadr = '0; e.sbe = 2'b00; e.soe = 1'b0; e.swe = 1'b0;
        e.sdat = 16'h0; e.cmpDat = 1'b0; e.ddat = v.expDat; e.name = {v.name, "_ack"};
        expQ.push_back(e);
        cycles = n * (W + 1) + 1;
    endtask

    task automatic checkOutput();
        exp_t e;
        logic ok;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty: got no expected entry, required one per cycle");
            return;
        end
        e = expQ.pop_front();
        if (e.isAck)
            ok = (dack_o === 1'b1) && (soe_o === 1'b0) && (swe_o === 1'b0) &&
                 (sbe_o === 2'b00) && (ddat_o === e.ddat);
        else
            ok = (dack_o === 1'b0) && (ddat_o === 64'h0) && (soe_o === e.soe) &&
                 (swe_o === e.swe) && (sbe_o === e.sbe) && (sadr_o === e.sadr) &&
                 (!e.cmpDat || (sdat_o === e.sdat));
        if (!ok) begin
            failures++;
            $display("[TB] FAIL %s: got dack=%0b soe=%0b swe=%0b sbe=%b sadr=%h sdat=%h ddat=%h; expected dack=%0b soe=%0b swe=%0b sbe=%b sadr=%h sdat=%h ddat=%h",
                     e.name, dack_o, soe_o, swe_o, sbe_o, sadr_o, sdat_o, ddat_o,
                     e.isAck, e.soe, e.swe, e.sbe, e.sadr, e.sdat, e.ddat);
        end
    endtask

    task automatic checkZero(input string name, input logic full);
        logic ok;
        checks++;
        ok = (dack_o === 1'b0) && (soe_o === 1'b0) && (swe_o === 1'b0) &&
             (sbe_o === 2'b00) && (ddat_o === 64'h0) &&
             (!full || ((sadr_o === '0) && (sdat_o === 16'h0)));
        if (!ok) begin
            failures++;
            $display("[TB] FAIL %s: got dack=%0b soe=%0b swe=%0b sbe=%b sadr=%h sdat=%h ddat=%h; expected all zero",
                     name, dack_o, soe_o, swe_o, sbe_o, sadr_o, sdat_o, ddat_o);
        end
    endtask

    task automatic runVector(input vec_t v);
        int cycles;
        applyStimulus(v, cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (i == 0) scramble();
            checkOutput();
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
        mem[1] = 16'h80AA; mem[2] = 16'h1234; mem[3] = 16'h8000;
        mem[19'h7FFFC] = 16'h0001; mem[19'h7FFFD] = 16'h0002;
        mem[19'h7FFFE] = 16'h0003; mem[19'h7FFFF] = 16'hF004;

        vecs.push_back('{1'b0, 2'b00, 1'b1, 64'h3,  64'h0, 64'hFFFF_FFFF_FFFF_FF80, "ldb_s_3"});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 64'h3,  64'h0, 64'h80,                  "ldb_u_3"});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 64'h2,  64'h0, 64'hFFFF_FFFF_FFFF_FFAA, "ldb_s_2"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 64'h5,  64'h0, 64'h1234,                "ldh_s_5"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 64'h6,  64'h0, 64'hFFFF_FFFF_FFFF_8000, "ldh_s_6"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 64'h6,  64'h0, 64'h8000_1234,           "ldw_u_6"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 64'h6,  64'h0, 64'hFFFF_FFFF_8000_1234, "ldw_s_6"});
        vecs.push_back('{1'b1, 2'b11, 1'b1, 64'h10, 64'h1122_3344_5566_7788, 64'h0, "std_10"});
        vecs.push_back('{1'b0, 2'b11, 1'b1, 64'h10, 64'h0, 64'h1122_3344_5566_7788, "ldd_s_10"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 64'h14, 64'h0, 64'h1122_3344,           "ldw_s_14"});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 64'h21, 64'hDEAD_BEEF_0000_12A5, 64'h0, "stb_21"});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 64'h21, 64'h0, 64'hFFFF_FFFF_FFFF_FFA5, "ldb_s_21"});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 64'h20, 64'h0, 64'h0,                   "ldb_u_20"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 64'h20, 64'h0, 64'hA500,                "ldh_u_20"});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 64'h42, 64'h5555_5555_CAFE_F00D, 64'h0, "stw_42"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 64'h40, 64'h0, 64'hCAFE_F00D,           "ldw_u_40"});
        vecs.push_back('{1'b1, 2'b01, 1'b1, 64'h31, 64'h0000_0000_7777_BEEF, 64'h0, "sth_31"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 64'h30, 64'h0, 64'hFFFF_FFFF_FFFF_BEEF, "ldh_s_30"});
        vecs.push_back('{1'b0, 2'b11, 1'b1, 64'hABCD_0000_00FF_FFFC, 64'h0, 64'hF004_0003_0002_0001, "ldd_wrap"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 64'h000F_FFFE, 64'h0, 64'hF004,                 "ldh_top"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 64'h001F_FFFE, 64'h0, 64'hFFFF_FFFF_F004_0003, "ldw_top"});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 64'h000F_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, "ldb_top"});

        reset_i = 1'b1;
        dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'($urandom); dsiz_i = 2'($urandom);
        dsigned_i = 1'($urandom); dadr_i = {$urandom, $urandom}; ddat_i = {$urandom, $urandom};
        @(negedge clk);
        checkZero("reset_cycle1", 1'b1);
        dadr_i = {$urandom, $urandom}; dwe_i = 1'($urandom);
        @(negedge clk);
        checkZero("reset_cycle2", 1'b1);
        reset_i = 1'b0;
        scramble();
        @(negedge clk);
        checkZero("idle_after_reset", 1'b1);

        for (int i = 0; i < vecs.size(); i++) runVector(vecs[i]);

        // Abort a dword load during its third beat, then confirm a clean restart.
        @(negedge clk);
        dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'b0; dsiz_i = 2'b11;
        dsigned_i = 1'b0; dadr_i = 64'h10; ddat_i = 64'h0;
        @(negedge clk);
        scramble();
        repeat (4) @(negedge clk);
        checks++;
        if (!(soe_o === 1'b1 && swe_o === 1'b0 && sadr_o === AW'(10) && sbe_o === 2'b11 &&
              dack_o === 1'b0)) begin
            failures++;
            $display("[TB] FAIL abort_in_beat2: got soe=%0b swe=%0b sadr=%h sbe=%b dack=%0b; expected soe=1 swe=0 sadr=0000a sbe=11 dack=0",
                     soe_o, swe_o, sadr_o, sbe_o, dack_o);
        end
        reset_i = 1'b1;
        @(negedge clk);
        checkZero("reset_mid_dword", 1'b1);
        reset_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkZero("no_ack_after_abort", 1'b0);
        end
        runVector('{1'b0, 2'b00, 1'b0, 64'h3, 64'h0, 64'h80, "ldb_after_abort"});

        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
